// File: rtl/smc_region_check_pkg.sv
// Package for the SMC region checker: lock FSM encoding, table limits and a
// helper deciding whether a table index addresses an existing entry.
// No ports; imported by smc_region_check.
`include "smc_defines.sv"

package smc_region_check_pkg;

  localparam int unsigned SMC_NREG_MAX = `SMC_NREG_MAX;
  localparam int unsigned SMC_AW_DEF   = `SMC_AW_DEFAULT;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  // An index is usable only if it names one of the NREG implemented entries;
  // IDW may be wider than strictly needed when NREG is not a power of two.
  function automatic logic idx_in_range(input int unsigned idx,
                                        input int unsigned nreg);
    return (idx < nreg);
  endfunction

endpackage

// File: rtl/smc_defines.sv
// Shared constants for the SMC region checker: table size limit, default
// address width, and the bit layout of one packed region table entry.
// Layout of an entry, LSB first: lo[AW-1:0], hi[AW-1:0], en.
`ifndef SMC_DEFINES_SV
`define SMC_DEFINES_SV

`define SMC_NREG_MAX      16
`define SMC_AW_DEFAULT    32
`define SMC_ENT_W(aw)     (2*(aw)+1)
`define SMC_LO_OFS(aw)    0
`define SMC_HI_OFS(aw)    (aw)
`define SMC_EN_OFS(aw)    (2*(aw))

`endif

// File: rtl/smc_region_cmp.sv
// Single-window comparator: match_o = en_i & lo_i <= addr_i <= hi_i (unsigned).
// Ports: lo_i/hi_i inclusive bounds, en_i entry valid, addr_i address under
// test, match_o combinational result. lo_i > hi_i simply never matches.
module smc_region_cmp #(
  parameter int AW = 32
) (
  input  logic [AW-1:0] lo_i,
  input  logic [AW-1:0] hi_i,
  input  logic          en_i,
  input  logic [AW-1:0] addr_i,
  output logic          match_o
);

  assign match_o = en_i && (addr_i >= lo_i) && (addr_i <= hi_i);

endmodule

// File: rtl/smc_region_check.sv
// Multi-region secure-memory-context address checker: NREG programmable
// [lo,hi] windows with a lockable table; one lookup per cycle, result 1 cycle later.
// Ports: cfg_* table write/clear/lock with cfg_err/locked status; ce/addr lookup
// request; hit_vld/hit/hit_id/multi_hit registered lookup result.
`include "smc_defines.sv"

module smc_region_check
  import smc_region_check_pkg::*;
#(
  parameter int NREG = 4,
  parameter int AW   = 32,
  parameter int IDW  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_we,
  input  logic [IDW-1:0] cfg_idx,
  input  logic [AW-1:0]  cfg_lo,
  input  logic [AW-1:0]  cfg_hi,
  input  logic           cfg_en,
  input  logic           cfg_clr,
  input  logic           cfg_lock,
  output logic           cfg_err,
  output logic           locked,
  input  logic           ce,
  input  logic [AW-1:0]  addr,
  output logic           hit_vld,
  output logic           hit,
  output logic [IDW-1:0] hit_id,
  output logic           multi_hit
);

  localparam int ENT_W  = `SMC_ENT_W(AW);
  localparam int LO_OFS = `SMC_LO_OFS(AW);
  localparam int HI_OFS = `SMC_HI_OFS(AW);
  localparam int EN_OFS = `SMC_EN_OFS(AW);

  // ---------------------------------------------------------------------------
  // Lock FSM. Clear wins over lock so a context teardown always reopens the table.
  // ---------------------------------------------------------------------------
  lock_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (cfg_clr) begin
      state_d = ST_UNLOCKED;
    end else if (cfg_lock) begin
      state_d = ST_LOCKED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  assign locked = (state_q == ST_LOCKED);

  // ---------------------------------------------------------------------------
  // Region table. Write acceptance uses the pre-edge lock state, so a write
  // issued together with cfg_lock still lands.
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0] ent_q [NREG];
  logic             idx_ok;
  logic             wr_ok;
  logic             cfg_err_q;

  assign idx_ok = idx_in_range(int'(cfg_idx), NREG);
  assign wr_ok  = cfg_we && !locked && idx_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        ent_q[i] <= '0;
      end
    end else if (cfg_clr) begin
      // Only the valid bits are cleared; stale bounds are harmless once en=0.
      for (int i = 0; i < NREG; i++) begin
        ent_q[i][EN_OFS] <= 1'b0;
      end
    end else if (wr_ok) begin
      for (int i = 0; i < NREG; i++) begin
        if (int'(cfg_idx) == i) begin
          ent_q[i] <= {cfg_en, cfg_hi, cfg_lo};
        end
      end
    end
  end

  // A rejected write is flagged whether or not a clear happens in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && (locked || !idx_ok);
    end
  end

  assign cfg_err = cfg_err_q;

  // ---------------------------------------------------------------------------
  // Comparator array against the current (pre-write) table contents.
  // ---------------------------------------------------------------------------
  logic [NREG-1:0] match;

  for (genvar g = 0; g < NREG; g++) begin : g_cmp
    smc_region_cmp #(
      .AW (AW)
    ) u_cmp (
      .lo_i    (ent_q[g][LO_OFS +: AW]),
      .hi_i    (ent_q[g][HI_OFS +: AW]),
      .en_i    (ent_q[g][EN_OFS]),
      .addr_i  (addr),
      .match_o (match[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Priority encoder and popcount>=2: any match after the first one found
  // means at least two windows overlap this address.
  // ---------------------------------------------------------------------------
  logic           hit_d;
  logic [IDW-1:0] hit_id_d;
  logic           multi_d;

  always_comb begin
    hit_d    = 1'b0;
    hit_id_d = '0;
    multi_d  = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (match[i]) begin
        if (hit_d) begin
          multi_d = 1'b1;
        end else begin
          hit_d    = 1'b1;
          hit_id_d = IDW'(i);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result register stage; idle cycles return an all-zero result.
  // ---------------------------------------------------------------------------
  logic           hit_vld_q;
  logic           hit_q;
  logic [IDW-1:0] hit_id_q;
  logic           multi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_vld_q <= 1'b0;
      hit_q     <= 1'b0;
      hit_id_q  <= '0;
      multi_q   <= 1'b0;
    end else begin
      hit_vld_q <= ce;
      hit_q     <= ce && hit_d;
      hit_id_q  <= ce ? hit_id_d : '0;
      multi_q   <= ce && multi_d;
    end
  end

  assign hit_vld   = hit_vld_q;
  assign hit       = hit_q;
  assign hit_id    = hit_id_q;
  assign multi_hit = multi_q;

endmodule
